// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-byte operation sequencer driving an 8-bit ALU one byte per clock
module alu_seq #(
   parameter int NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [8*NBYTES-1:0]   opa,
   input  logic [8*NBYTES-1:0]   opb,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [8*NBYTES-1:0]   result,
   output logic                  carry_out,
   output logic                  parity,
   output logic [3:0]            alu_cmd,
   output logic [7:0]            alu_a,
   output logic [7:0]            alu_b,
   output logic                  alu_sc_i,
   output logic                  alu_pari_in,
   input  logic [7:0]            alu_rslt,
   input  logic                  alu_sc_o,
   input  logic                  alu_sc_en,
   input  logic                  alu_sc_clr,
   input  logic                  alu_pari,
   input  logic                  alu_pari_en,
   input  logic                  alu_pari_clr
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd2;
   localparam logic [2:0] OP_LSR = 3'd3;
   localparam logic [2:0] OP_ASR = 3'd4;
   localparam logic [2:0] OP_PAR = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q;
   logic [2:0]      op_q;
   logic [W-1:0]    opa_q, opb_q, result_q;
   logic [IW-1:0]   idx_q, byte_sel;
   logic            sc_q, pari_q, sc_d, pari_d;
   logic            busy_q, done_q, err_q, carry_out_q, parity_q;
   logic            run, first;
   int              base;

   always_comb begin
      run         = (state_q == S_RUN);
      first       = (idx_q == '0);
      byte_sel    = ((op_q == OP_LSR) || (op_q == OP_ASR)) ? (LAST - idx_q) : idx_q;
      base        = 8 * int'(byte_sel);
      alu_cmd     = 4'd0;
      alu_a       = 8'd0;
      alu_b       = 8'd0;
      alu_sc_i    = 1'b0;
      alu_pari_in = 1'b0;
      if (run) begin
         alu_a       = opa_q[base +: 8];
         alu_sc_i    = first ? (op_q == OP_SUB) : sc_q;
         alu_pari_in = first ? 1'b0 : pari_q;
         case (op_q)
            OP_ADD, OP_SUB: begin
               alu_cmd = 4'd0;
               alu_b   = opb_q[base +: 8];
            end
            OP_SHL:  alu_cmd = 4'd2;
            OP_LSR:  alu_cmd = 4'd4;
            OP_ASR:  alu_cmd = first ? 4'd3 : 4'd4;
            OP_PAR:  alu_cmd = 4'd8;
            default: alu_cmd = 4'd0;
         endcase
      end
      // Load beats clear when the ALU asserts both in the same cycle.
      sc_d = sc_q;
      if (alu_sc_en)       sc_d = alu_sc_o;
      else if (alu_sc_clr) sc_d = 1'b0;
      pari_d = pari_q;
      if (alu_pari_en)       pari_d = alu_pari;
      else if (alu_pari_clr) pari_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         opa_q       <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         idx_q       <= '0;
         sc_q        <= 1'b0;
         pari_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         carry_out_q <= 1'b0;
         parity_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q     <= op;
                  opa_q    <= opa;
                  opb_q    <= (op == OP_SUB) ? ~opb : opb;
                  result_q <= '0;
                  sc_q     <= 1'b0;
                  pari_q   <= 1'b0;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  err_q    <= (op > OP_PAR);
                  if (op > OP_PAR) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     carry_out_q <= 1'b0;
                     parity_q    <= 1'b0;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               sc_q                <= sc_d;
               pari_q              <= pari_d;
               result_q[base +: 8] <= alu_rslt;
               idx_q               <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  carry_out_q <= sc_d;
                  parity_q    <= pari_d;
                  if (op_q == OP_PAR)
                     result_q <= {{(W-1){1'b0}}, pari_d};
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign parity    = parity_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-byte operation sequencer for the 8-bit ALU. It accepts one NBYTES-wide operation (add, sub, shift, parity) from the control unit and issues one ALU byte-operation per clock. It chains shift-carry and parity through its own flag registers, which it updates from the ALU's sc_en/sc_clr/pari_en/pari_clr outputs. It sits between the control unit and the ALU and drives every ALU input while busy.

Parameters:
NBYTES, 2, operand width in bytes (>=2); W = 8*NBYTES

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0 ADD, 1 SUB, 2 SHL, 3 LSR, 4 ASR, 5 PAR, 6-7 illegal
opa  in  W  operand A
opb  in  W  operand B (ADD/SUB only)
busy  out  1  high in RUN and DONE
done  out  1  one-cycle completion pulse
err  out  1  sticky illegal-op flag; cleared by next accepted start
result  out  W  result; held until next accepted start
carry_out  out  1  final sc flag
parity  out  1  final parity flag
alu_cmd  out  4  to ALU alu_cmd
alu_a  out  8  to ALU inA
alu_b  out  8  to ALU inB
alu_sc_i  out  1  to ALU sc_i
alu_pari_in  out  1  to ALU pari_in
alu_rslt  in  8  from ALU rslt
alu_sc_o, alu_sc_en, alu_sc_clr  in  1 each  from ALU
alu_pari, alu_pari_en, alu_pari_clr  in  1 each  from ALU

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset forces IDLE and sets busy, done, err, result, carry_out, parity, sc_q, pari_q, idx and the latched operands to 0. Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: on start, latch op, opa and opb (opb inverted for SUB); clear result, sc_q, pari_q and err; idx=0; go to RUN. Illegal op goes to DONE with err=1 and result=0.
  - RUN: one byte per cycle, idx 0..NBYTES-1. On the last cycle, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. start during RUN or DONE is ignored.
- Latency: the start-sampling edge is k. done is high in the cycle after edge k+NBYTES. Total occupancy is NBYTES+1 cycles.
- Byte order:
  - ADD, SUB, SHL, PAR: LSB byte first (byte = idx).
  - LSR, ASR: MSB byte first (byte = NBYTES-1-idx).
- Byte issue per op:
  - ADD: alu_cmd=0, alu_b = opb byte.
  - SUB: alu_cmd=0, alu_b = inverted opb byte, seed carry=1. carry_out=1 means no borrow.
  - SHL: alu_cmd=2.
  - LSR: alu_cmd=4.
  - ASR: alu_cmd=3 on the first (MSB) byte, alu_cmd=4 on the rest.
  - PAR: alu_cmd=8.
- Carry and parity chaining:
  - alu_sc_i = seed on idx 0 (0, or 1 for SUB), else sc_q.
  - alu_pari_in = 0 on idx 0, else pari_q.
- Flag registers, updated only in RUN, priority en over clr:
  - sc_q loads alu_sc_o if alu_sc_en; else clears if alu_sc_clr; else holds.
  - pari_q loads alu_pari if alu_pari_en; else clears if alu_pari_clr.
- Result capture: each RUN cycle, alu_rslt is written into the result byte for that idx. For PAR, result = {zeros, final pari_q}.
- On entering DONE: carry_out <= sc_q, parity <= pari_q.
- Outside RUN: alu_cmd=0 and all ALU data outputs are 0. ALU flag outputs are ignored.

Test Plan:
- ADD 0x12FF+0x0001 (NBYTES=2) -> result 0x1300, carry_out 0, done exactly 2 edges after start edge. ADD 0xFFFF+0x0001 -> 0x0000, carry_out 1.
- SUB 0x1000-0x0001 -> 0x0FFF, carry_out 1. SUB 0x0000-0x0001 -> 0xFFFF, carry_out 0.
- SHL 0x8001 -> 0x0002, carry_out 1. LSR 0x8001 -> 0x4000, carry_out 1. ASR 0x8002 -> 0xC001, carry_out 0.
- PAR opa=0x0103 -> result 0x0001, parity 1. PAR 0x0303 -> result 0x0000, parity 0.
- start pulsed during RUN with different op -> ignored; first result intact; single done pulse. op=6 -> done next cycle, err=1, result 0x0000.
- reset asserted mid-RUN (asynchronous, between edges) -> busy/done/result immediately 0, FSM IDLE, no done. A new ADD afterwards completes normally.
